// File: rtl/imem_load_arbiter.sv
// imem_load_arbiter: shares the instruction-RAM port between the CPU fetch
// stage and the UART program loader. A load session stalls fetch, drains
// the in-flight read, lets the loader write, then holds the core in reset
// so it restarts from the reset PC.
module imem_load_arbiter #(
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 32,
    parameter int RELEASE_CYC = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_req,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_wdata,
    input  logic              load_done,
    input  logic [31:0]       fetch_pc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              load_grant,
    output logic              cpu_hold,
    output logic              cpu_rst_n,
    output logic [ADDR_W:0]   word_count,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_LOAD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // Word count saturates at exactly 2^ADDR_W (one full RAM image).
    localparam logic [ADDR_W:0] WC_MAX   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [3:0]      REL_INIT = 4'(RELEASE_CYC - 1);

    state_t            state_q, state_d;
    logic              load_grant_q, load_grant_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic [3:0]        rel_cnt_q, rel_cnt_d;

    // Only the word-address slice of the PC is used; the rest is folded here
    // so the remaining bits are visibly intentional.
    logic unused_fetch_bits;
    assign unused_fetch_bits = ^fetch_pc;

    // Port mux: the loader drives the RAM only in LOAD, so a stray load_we
    // in any other state can never reach the array.
    always_comb begin
        mem_addr  = fetch_pc[ADDR_W+1:2];
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (state_q == ST_LOAD) begin
            mem_addr  = load_addr;
            mem_wdata = load_wdata;
            mem_we    = load_we;
        end
    end

    // Next-state and registered-output logic for the session FSM.
    always_comb begin
        state_d      = state_q;
        load_grant_d = load_grant_q;
        cpu_hold_d   = cpu_hold_q;
        cpu_rst_n_d  = cpu_rst_n_q;
        word_count_d = word_count_q;
        rel_cnt_d    = rel_cnt_q;
        unique case (state_q)
            ST_RUN: begin
                cpu_rst_n_d = 1'b1;
                if (load_req) begin
                    state_d      = ST_DRAIN;
                    cpu_hold_d   = 1'b1;
                    word_count_d = '0;
                end
            end
            ST_DRAIN: begin
                // One cycle lets the fetch read already issued complete.
                state_d      = ST_LOAD;
                load_grant_d = 1'b1;
            end
            ST_LOAD: begin
                // A write coinciding with the end of the session still counts.
                if (load_we && (word_count_q != WC_MAX))
                    word_count_d = word_count_q + 1'b1;
                if (load_done || !load_req) begin
                    state_d      = ST_RELEASE;
                    load_grant_d = 1'b0;
                    cpu_rst_n_d  = 1'b0;
                    rel_cnt_d    = REL_INIT;
                end
            end
            ST_RELEASE: begin
                cpu_hold_d  = 1'b1;
                cpu_rst_n_d = 1'b0;
                if (rel_cnt_q == 4'd0) begin
                    state_d     = ST_RUN;
                    cpu_hold_d  = 1'b0;
                    cpu_rst_n_d = 1'b1;
                end else begin
                    rel_cnt_d = rel_cnt_q - 4'd1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State register with synchronous active-low reset; core reset is held
    // low while reset is asserted.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            load_grant_q <= 1'b0;
            cpu_hold_q   <= 1'b0;
            cpu_rst_n_q  <= 1'b0;
            word_count_q <= '0;
            rel_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            load_grant_q <= load_grant_d;
            cpu_hold_q   <= cpu_hold_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
            word_count_q <= word_count_d;
            rel_cnt_q    <= rel_cnt_d;
        end
    end

    assign load_grant = load_grant_q;
    assign cpu_hold   = cpu_hold_q;
    assign cpu_rst_n  = cpu_rst_n_q;
    assign word_count = word_count_q;
    assign state      = state_q;

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Directed bench for imem_load_arbiter: a default-size instance and an
// ADDR_W=2 instance for word-count saturation.
module tb_imem_load_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_req, load_we, load_done;
    logic [13:0] load_addr;
    logic [31:0] load_wdata, fetch_pc;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we, load_grant, cpu_hold, cpu_rst_n;
    logic [14:0] word_count;
    logic [1:0]  state;

    logic        s_req, s_we, s_done;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata, s_pc;
    logic [1:0]  s_mem_addr;
    logic [31:0] s_mem_wdata;
    logic        s_mem_we, s_grant, s_hold, s_rst_n;
    logic [2:0]  s_wc;
    logic [1:0]  s_state;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    imem_load_arbiter dut (
        .clock(clock), .reset(reset), .load_req(load_req), .load_we(load_we),
        .load_addr(load_addr), .load_wdata(load_wdata), .load_done(load_done),
        .fetch_pc(fetch_pc), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .load_grant(load_grant), .cpu_hold(cpu_hold),
        .cpu_rst_n(cpu_rst_n), .word_count(word_count), .state(state)
    );

    imem_load_arbiter #(.ADDR_W(2), .DATA_W(32), .RELEASE_CYC(4)) dut_s (
        .clock(clock), .reset(reset), .load_req(s_req), .load_we(s_we),
        .load_addr(s_addr), .load_wdata(s_wdata), .load_done(s_done),
        .fetch_pc(s_pc), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .mem_we(s_mem_we), .load_grant(s_grant), .cpu_hold(s_hold),
        .cpu_rst_n(s_rst_n), .word_count(s_wc), .state(s_state)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (load_grant !== 1'b0) begin errors++; $display("FAIL reset_grant got=%b exp=0", load_grant); end
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL reset_hold got=%b exp=0", cpu_hold); end
        checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL reset_cpu_rst_n got=%b exp=0", cpu_rst_n); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if (word_count !== 15'd0) begin errors++; $display("FAIL reset_wc got=%0d exp=0", word_count); end
        reset = 1'b1;
        tick();
        checks++; if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL release_cpu_rst_n got=%b exp=1", cpu_rst_n); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL release_state got=%0d exp=0", state); end
    endtask

    task automatic test_run_mux();
        fetch_pc = 32'h0000_0040;
        load_we  = 1'b1;
        load_addr = 14'h3FF;
        #1;
        checks++; if (mem_addr !== 14'h010) begin errors++; $display("FAIL run_mem_addr got=%h exp=010", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL run_mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_wdata !== 32'd0) begin errors++; $display("FAIL run_mem_wdata got=%h exp=0", mem_wdata); end
        tick();
        checks++; if (word_count !== 15'd0) begin errors++; $display("FAIL run_wc got=%0d exp=0", word_count); end
        load_we = 1'b0;
        // load_done outside LOAD is ignored.
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        checks++; if (state !== 2'd0 || cpu_rst_n !== 1'b1) begin errors++; $display("FAIL done_in_run state=%0d rst_n=%b exp=0/1", state, cpu_rst_n); end
    endtask

    task automatic test_load();
        load_req = 1'b1;
        tick();
        checks++; if (cpu_hold !== 1'b1 || load_grant !== 1'b0 || state !== 2'd1) begin
            errors++; $display("FAIL t1 hold=%b grant=%b state=%0d exp=1/0/1", cpu_hold, load_grant, state); end
        tick();
        checks++; if (load_grant !== 1'b1 || state !== 2'd2) begin
            errors++; $display("FAIL t2 grant=%b state=%0d exp=1/2", load_grant, state); end
        for (int i = 0; i < 3; i++) begin
            load_we    = 1'b1;
            load_addr  = 14'(i);
            load_wdata = 32'hDEADBEEF + 32'(i);
            #1;
            checks++; if (mem_we !== 1'b1 || mem_addr !== 14'(i) || mem_wdata !== 32'hDEADBEEF + 32'(i)) begin
                errors++; $display("FAIL write%0d we=%b addr=%h data=%h exp=1/%h/%h", i, mem_we, mem_addr, mem_wdata, i, 32'hDEADBEEF + 32'(i)); end
            tick();
        end
        load_we = 1'b0;
        checks++; if (word_count !== 15'd3) begin errors++; $display("FAIL wc3 got=%0d exp=3", word_count); end
    endtask

    task automatic test_done_release();
        int low;
        load_we = 1'b1; load_addr = 14'd5; load_wdata = 32'hCAFEF00D; load_done = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 14'd5) begin
            errors++; $display("FAIL done_write we=%b addr=%h exp=1/005", mem_we, mem_addr); end
        tick();
        load_we = 1'b0; load_done = 1'b0; load_req = 1'b0;
        checks++; if (word_count !== 15'd4) begin errors++; $display("FAIL wc4 got=%0d exp=4", word_count); end
        checks++; if (state !== 2'd3 || load_grant !== 1'b0 || cpu_hold !== 1'b1) begin
            errors++; $display("FAIL enter_release state=%0d grant=%b hold=%b exp=3/0/1", state, load_grant, cpu_hold); end
        low = (cpu_rst_n === 1'b0) ? 1 : 0;
        for (int i = 0; i < 20 && cpu_rst_n === 1'b0; i++) begin
            tick();
            if (cpu_rst_n === 1'b0) low++;
        end
        checks++; if (low != 4) begin errors++; $display("FAIL rst_low_cycles got=%0d exp=4", low); end
        checks++; if (cpu_hold !== 1'b0 || state !== 2'd0) begin
            errors++; $display("FAIL back_to_run hold=%b state=%0d exp=0/0", cpu_hold, state); end
        tick();
        checks++; if (word_count !== 15'd4) begin errors++; $display("FAIL wc_hold got=%0d exp=4", word_count); end
    endtask

    task automatic test_back_to_back();
        load_req = 1'b1;
        tick(); tick();
        load_we = 1'b1; load_addr = 14'd9;
        tick();
        load_we = 1'b0; load_done = 1'b1;
        tick();
        load_done = 1'b0;
        checks++; if (state !== 2'd3 || word_count !== 15'd1) begin
            errors++; $display("FAIL b2b_release state=%0d wc=%0d exp=3/1", state, word_count); end
        repeat (4) tick();
        checks++; if (state !== 2'd0 || cpu_hold !== 1'b0 || cpu_rst_n !== 1'b1) begin
            errors++; $display("FAIL b2b_run state=%0d hold=%b rst_n=%b exp=0/0/1", state, cpu_hold, cpu_rst_n); end
        tick();
        checks++; if (state !== 2'd1 || word_count !== 15'd0 || cpu_hold !== 1'b1) begin
            errors++; $display("FAIL b2b_drain state=%0d wc=%0d hold=%b exp=1/0/1", state, word_count, cpu_hold); end
        tick();
        checks++; if (state !== 2'd2 || load_grant !== 1'b1) begin
            errors++; $display("FAIL b2b_load state=%0d grant=%b exp=2/1", state, load_grant); end
    endtask

    task automatic test_reset_mid_load();
        load_we = 1'b1; load_addr = 14'd7;
        tick();
        checks++; if (word_count !== 15'd1) begin errors++; $display("FAIL pre_reset_wc got=%0d exp=1", word_count); end
        reset = 1'b0;
        tick();
        checks++; if (mem_we !== 1'b0 || state !== 2'd0 || load_grant !== 1'b0 || word_count !== 15'd0) begin
            errors++; $display("FAIL mid_reset we=%b state=%0d grant=%b wc=%0d exp=0/0/0/0", mem_we, state, load_grant, word_count); end
        checks++; if (cpu_rst_n !== 1'b0 || cpu_hold !== 1'b0) begin
            errors++; $display("FAIL mid_reset_cpu rst_n=%b hold=%b exp=0/0", cpu_rst_n, cpu_hold); end
        load_we = 1'b0; load_req = 1'b0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_saturate();
        s_req = 1'b1;
        tick(); tick();
        checks++; if (s_state !== 2'd2) begin errors++; $display("FAIL sat_load state=%0d exp=2", s_state); end
        for (int i = 0; i < 5; i++) begin
            s_we = 1'b1; s_addr = 2'(i); s_wdata = 32'h100 + 32'(i);
            #1;
            checks++; if (s_mem_we !== 1'b1 || s_mem_addr !== 2'(i)) begin
                errors++; $display("FAIL sat_write%0d we=%b addr=%0d exp=1/%0d", i, s_mem_we, s_mem_addr, i % 4); end
            tick();
        end
        s_we = 1'b0;
        checks++; if (s_wc !== 3'd4) begin errors++; $display("FAIL sat_wc got=%0d exp=4", s_wc); end
        s_req = 1'b0;
        tick();
        checks++; if (s_state !== 2'd3 || s_wc !== 3'd4) begin
            errors++; $display("FAIL sat_release state=%0d wc=%0d exp=3/4", s_state, s_wc); end
    endtask

    initial begin
        reset = 1'b0; load_req = 1'b0; load_we = 1'b0; load_done = 1'b0;
        load_addr = '0; load_wdata = '0; fetch_pc = '0;
        s_req = 1'b0; s_we = 1'b0; s_done = 1'b0; s_addr = '0; s_wdata = '0; s_pc = '0;
        test_reset();
        test_run_mux();
        test_load();
        test_done_release();
        test_back_to_back();
        test_reset_mid_load();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
